demux_sel_sequencer: RTL and testbench

//   Upstream sequencer for the 1xN demultiplexer (demux_1xn). Drives the

---
 rtl/demux_sel_sequencer.sv | 127 ++++++++++++
 tb/tb_demux_sel_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux_sel_sequencer.sv
// Select/data sequencer feeding a 1xN demux: steps S over all channels with a
// fixed dwell, keeps a registered copy of what each channel last received.
module demux_sel_sequencer #(
  parameter int N     = 8,
  parameter int SW    = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic          stop,
  input  logic          d_in,
  output logic          D,
  output logic [SW-1:0] S,
  output logic          busy,
  output logic          done,
  output logic          ch_valid,
  output logic [N-1:0]  hold
);

  // state    | meaning
  // IDLE     | waiting for start; stop requests are discarded
  // DRIVE    | presenting channel S with data D for DWELL cycles
  // DONE     | one-cycle end-of-scan marker, outputs parked at 0
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic          stop_pend_q;
  logic          data_q;
  logic [SW-1:0] sel_q;
  logic          busy_q;
  logic          done_q;
  logic          chv_q;
  logic [N-1:0]  hold_q;

  // A stop arriving on the channel-end edge itself still ends the scan there.
  logic stop_hit;
  assign stop_hit = stop_pend_q | stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      data_q      <= 1'b0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chv_q       <= 1'b0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q      <= 1'b0;
          chv_q       <= 1'b0;
          stop_pend_q <= 1'b0;
          if (start) begin
            state_q <= ST_DRIVE;
            busy_q  <= 1'b1;
            sel_q   <= '0;
            data_q  <= d_in;
            cnt_q   <= '0;
            mode_q  <= mode;
          end
        end
        ST_DRIVE: begin
          chv_q       <= 1'b0;
          stop_pend_q <= stop_hit;
          if (cnt_q == CNT_LAST) begin
            hold_q[sel_q] <= data_q;
            chv_q         <= 1'b1;
            cnt_q         <= '0;
            if (sel_q != SEL_LAST && !stop_hit) begin
              sel_q  <= sel_q + 1'b1;
              data_q <= d_in;
            end else if (sel_q == SEL_LAST && mode_q && !stop_hit) begin
              sel_q  <= '0;
              data_q <= d_in;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sel_q   <= '0;
              data_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          done_q      <= 1'b0;
          chv_q       <= 1'b0;
          stop_pend_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          chv_q   <= 1'b0;
          sel_q   <= '0;
          data_q  <= 1'b0;
        end
      endcase
    end
  end

  assign D        = data_q;
  assign S        = sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ch_valid = chv_q;
  assign hold     = hold_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: per-cycle expectations derived from channel
// index arithmetic (t / DWELL) and a per-channel record of sampled d_in.
module tb_demux_sel_sequencer;

  localparam int N  = 8;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, stop, d_in;
  logic D, busy, done, chv;
  logic [2:0] S;
  logic [7:0] hold;

  logic start1, mode1, stop1, d1;
  logic D1, busy1, done1, chv1;
  logic [2:0] S1;
  logic [7:0] hold1;

  demux_sel_sequencer #(.N(N), .SW(3), .DWELL(DW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop(stop), .d_in(d_in),
    .D(D), .S(S), .busy(busy), .done(done), .ch_valid(chv), .hold(hold)
  );

  demux_sel_sequencer #(.N(N), .SW(3), .DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .stop(stop1), .d_in(d1),
    .D(D1), .S(S1), .busy(busy1), .done(done1), .ch_valid(chv1), .hold(hold1)
  );

  int checks = 0;
  int failures = 0;
  bit hold_m [N];
  bit dh [128];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hold_exp();
    logic [7:0] v;
    for (int i = 0; i < N; i++) v[i] = hold_m[i];
    return v;
  endfunction

  function automatic bit pat(input int dpat, input int c);
    if (dpat == 1) return 1'b1;
    if (dpat == 2) return bit'(c % 2);
    return bit'($urandom_range(0, 1));
  endfunction

  // One scan on the DWELL=4 instance. stop_at = cycle index (from first busy
  // cycle) whose closing edge carries a stop pulse, or -1 for none.
  task automatic scan(input bit md, input int stop_at, input int dpat, input bit noise);
    int len;
    int c;
    len = (stop_at >= 0) ? stop_at / DW + 1 : N;
    if (!md && len > N) len = N;
    dh[0] = pat(dpat, 0);
    start = 1'b1; mode = md; d_in = dh[0]; stop = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t <= len * DW; t++) begin
      c = t / DW;
      if (t < len * DW) begin
        chk("scan_S", 32'(S), 32'(c % N));
        chk("scan_D", 32'(D), 32'(dh[c]));
        chk("scan_busy", 32'(busy), 32'd1);
        chk("scan_done", 32'(done), 32'd0);
        chk("scan_chv", 32'(chv), 32'((t > 0) && (t % DW == 0)));
      end else begin
        chk("end_S", 32'(S), 32'd0);
        chk("end_D", 32'(D), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done), 32'd1);
        chk("end_chv", 32'(chv), 32'd1);
      end
      if (t % DW == DW - 1 && t < len * DW) begin
        dh[c + 1] = pat(dpat, c + 1);
        d_in = dh[c + 1];
      end else begin
        d_in = 1'($urandom_range(0, 1));
      end
      stop  = (t == stop_at);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (t == len * DW) start = noise;
      if (noise) mode = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_chv", 32'(chv), 32'd0);
    chk("idle_S", 32'(S), 32'd0);
    for (int k = 0; k < len; k++) hold_m[k % N] = dh[k];
    chk("hold", 32'(hold), 32'(hold_exp()));
  endtask

  initial begin
    int s;
    bit e1 [9];
    rst = 1'b1; start = 1'b0; mode = 1'b0; stop = 1'b0; d_in = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; stop1 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < N; i++) hold_m[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {26'd0, D, S, busy, done, chv}, 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_outs1", {26'd0, D1, S1, busy1, done1, chv1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-scan at S=3
    start = 1'b1; d_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_S", 32'(S), 32'd3);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {26'd0, D, S, busy, done, chv}, 32'd0);
    chk("arst_hold", 32'(hold), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    scan(1'b0, -1, 1, 1'b0);
    chk("hold_ff", 32'(hold), 32'hFF);
    scan(1'b0, -1, 2, 1'b0);
    chk("hold_aa", 32'(hold), 32'hAA);
    scan(1'b1, (N + 2) * DW + 1, 0, 1'b0);
    scan(1'b0, -1, 0, 1'b1);
    scan(1'b0, -1, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 60));
      if (s % DW == DW - 1) s--;
      scan(1'($urandom_range(0, 1)), s, 0, 1'b1);
    end

    // DWELL=1 instance
    e1[0] = 1'($urandom_range(0, 1));
    start1 = 1'b1; d1 = e1[0];
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int t = 0; t <= N; t++) begin
      if (t < N) begin
        chk("d1_S", 32'(S1), 32'(t));
        chk("d1_D", 32'(D1), 32'(e1[t]));
        chk("d1_busy", 32'(busy1), 32'd1);
        chk("d1_chv", 32'(chv1), 32'(t > 0));
        chk("d1_done", 32'(done1), 32'd0);
        e1[t + 1] = 1'($urandom_range(0, 1));
        d1 = e1[t + 1];
      end else begin
        chk("d1_end_busy", 32'(busy1), 32'd0);
        chk("d1_end_done", 32'(done1), 32'd1);
        chk("d1_end_chv", 32'(chv1), 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("d1_idle_chv", 32'(chv1), 32'd0);
    chk("d1_hold", 32'(hold1),
        32'({e1[7], e1[6], e1[5], e1[4], e1[3], e1[2], e1[1], e1[0]}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
